// File: rtl/alu_if.sv
// ALU bus: operands, command and enables toward the core; result and flags back.
interface alu_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 ce;
    logic                 mode;
    logic                 cin;
    logic [1:0]           inp_valid;
    logic [CMD_WIDTH-1:0] cmd;
    logic [WIDTH:0]       res;
    logic                 cout;
    logic                 oflow;
    logic                 g;
    logic                 l;
    logic                 e;
    logic                 err;

    modport master (
        output opa, opb, ce, mode, cin, inp_valid, cmd,
        input  res, cout, oflow, g, l, e, err
    );

    modport slave (
        input  opa, opb, ce, mode, cin, inp_valid, cmd,
        output res, cout, oflow, g, l, e, err
    );
endinterface

// File: rtl/alu_core.sv
// Registered arithmetic/logic unit, one-cycle latency, with operand-valid and
// illegal-command checking folded into a single err flag.
module alu_core #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave alu
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [CMD_WIDTH-1:0] A_ADD     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB     = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADD_CIN = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUB_CIN = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INC_A   = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DEC_A   = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INC_B   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DEC_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP     = CMD_WIDTH'(8);

    localparam logic [CMD_WIDTH-1:0] L_AND     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR      = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR     = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR     = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR    = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOT_A   = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOT_B   = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_A  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_A  = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SHR1_B  = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SHL1_B  = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL     = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR     = CMD_WIDTH'(13);

    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    logic [WIDTH:0]     res_d, res_q;
    logic               cout_d, cout_q;
    logic               oflow_d, oflow_q;
    logic               g_d, g_q;
    logic               l_d, l_q;
    logic               e_d, e_q;
    logic               err_d, err_q;

    logic               need_a, need_b, legal, rot_bad;
    logic [WIDTH:0]     a_x, b_x, c_x, diff_x;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] dbl, rol_sh, ror_sh;

    assign a_x    = {1'b0, alu.opa};
    assign b_x    = {1'b0, alu.opb};
    assign c_x    = {{WIDTH{1'b0}}, alu.cin};
    assign diff_x = a_x - b_x - c_x;
    assign amt    = alu.opb[SHW-1:0];
    // Rotation via a doubled operand: the window slid by amt wraps naturally.
    assign dbl    = {alu.opa, alu.opa};
    assign rol_sh = dbl << amt;
    assign ror_sh = dbl >> amt;

    always_comb begin
        res_d   = '0;
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        g_d     = 1'b0;
        l_d     = 1'b0;
        e_d     = 1'b0;
        need_a  = 1'b0;
        need_b  = 1'b0;
        legal   = 1'b1;
        rot_bad = 1'b0;
        if (alu.mode) begin
            unique case (alu.cmd)
                A_ADD:     begin need_a = 1'b1; need_b = 1'b1; res_d = a_x + b_x; cout_d = res_d[WIDTH]; end
                A_SUB:     begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, alu.opa - alu.opb}; oflow_d = (alu.opa < alu.opb); end
                A_ADD_CIN: begin need_a = 1'b1; need_b = 1'b1; res_d = a_x + b_x + c_x; cout_d = res_d[WIDTH]; end
                A_SUB_CIN: begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, diff_x[WIDTH-1:0]}; oflow_d = (a_x < (b_x + c_x)); end
                A_INC_A:   begin need_a = 1'b1; res_d = a_x + ONE_X; cout_d = res_d[WIDTH]; end
                A_DEC_A:   begin need_a = 1'b1; res_d = {1'b0, alu.opa - WIDTH'(1)}; oflow_d = (alu.opa == '0); end
                A_INC_B:   begin need_b = 1'b1; res_d = b_x + ONE_X; cout_d = res_d[WIDTH]; end
                A_DEC_B:   begin need_b = 1'b1; res_d = {1'b0, alu.opb - WIDTH'(1)}; oflow_d = (alu.opb == '0); end
                A_CMP: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    g_d    = (alu.opa > alu.opb);
                    l_d    = (alu.opa < alu.opb);
                    e_d    = (alu.opa == alu.opb);
                end
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (alu.cmd)
                L_AND:    begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, alu.opa & alu.opb}; end
                L_NAND:   begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, ~(alu.opa & alu.opb)}; end
                L_OR:     begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, alu.opa | alu.opb}; end
                L_NOR:    begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, ~(alu.opa | alu.opb)}; end
                L_XOR:    begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, alu.opa ^ alu.opb}; end
                L_XNOR:   begin need_a = 1'b1; need_b = 1'b1; res_d = {1'b0, ~(alu.opa ^ alu.opb)}; end
                L_NOT_A:  begin need_a = 1'b1; res_d = {1'b0, ~alu.opa}; end
                L_NOT_B:  begin need_b = 1'b1; res_d = {1'b0, ~alu.opb}; end
                L_SHR1_A: begin need_a = 1'b1; res_d = {1'b0, alu.opa >> 1}; end
                L_SHL1_A: begin need_a = 1'b1; res_d = {1'b0, alu.opa << 1}; end
                L_SHR1_B: begin need_b = 1'b1; res_d = {1'b0, alu.opb >> 1}; end
                L_SHL1_B: begin need_b = 1'b1; res_d = {1'b0, alu.opb << 1}; end
                L_ROL: begin
                    need_a  = 1'b1;
                    need_b  = 1'b1;
                    rot_bad = ((alu.opb >> SHW) != '0);
                    res_d   = {1'b0, rol_sh[2*WIDTH-1 -: WIDTH]};
                end
                L_ROR: begin
                    need_a  = 1'b1;
                    need_b  = 1'b1;
                    rot_bad = ((alu.opb >> SHW) != '0);
                    res_d   = {1'b0, ror_sh[WIDTH-1:0]};
                end
                default: legal = 1'b0;
            endcase
        end

        // Every legal command needs at least one operand, so inp_valid=00 always lands here.
        err_d = !legal || rot_bad || (need_a && !alu.inp_valid[0]) || (need_b && !alu.inp_valid[1]);
        if (err_d) begin
            res_d   = '0;
            cout_d  = 1'b0;
            oflow_d = 1'b0;
            g_d     = 1'b0;
            l_d     = 1'b0;
            e_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
        end else if (alu.ce) begin
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign alu.res   = res_q;
    assign alu.cout  = cout_q;
    assign alu.oflow = oflow_q;
    assign alu.g     = g_q;
    assign alu.l     = l_q;
    assign alu.e     = e_q;
    assign alu.err   = err_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: integer reference model checked every cycle,
// plus literal expectations per directed vector.
module tb_alu_core;
    localparam int W = 8;
    localparam int M = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchecks = 0;
    int   nfail   = 0;

    alu_if #(.WIDTH(W), .CMD_WIDTH(4)) bus ();

    alu_core #(.WIDTH(W), .CMD_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus.slave)
    );

    always #5 clk = ~clk;

    // Packed as {res[8:0], cout, oflow, g, l, e, err}
    function automatic logic [14:0] model(input logic md, input int c, input int a, input int b,
                                          input int ci, input logic [1:0] iv);
        int r = 0;
        bit co = 0, of = 0, gg = 0, ll = 0, ee = 0, bad = 0;
        bit na = 0, nb = 0;
        logic [7:0] va, vb, t;
        va = 8'(a);
        vb = 8'(b);
        if (md) begin
            case (c)
                0: begin r = a + b; co = (r >= M); end
                1: begin r = (a - b + M) % M; of = (a < b); end
                2: begin r = a + b + ci; co = (r >= M); end
                3: begin r = (a - b - ci + 2*M) % M; of = (a < b + ci); end
                4: begin r = a + 1; co = (r >= M); end
                5: begin r = (a + M - 1) % M; of = (a == 0); end
                6: begin r = b + 1; co = (r >= M); end
                7: begin r = (b + M - 1) % M; of = (b == 0); end
                8: begin gg = (a > b); ll = (a < b); ee = (a == b); end
                default: bad = 1;
            endcase
            if (c <= 3 || c == 8) begin na = 1; nb = 1; end
            if (c == 4 || c == 5) na = 1;
            if (c == 6 || c == 7) nb = 1;
        end else begin
            case (c)
                0: t = va & vb;
                1: t = ~(va & vb);
                2: t = va | vb;
                3: t = ~(va | vb);
                4: t = va ^ vb;
                5: t = ~(va ^ vb);
                6: t = ~va;
                7: t = ~vb;
                8: t = va >> 1;
                9: t = va << 1;
                10: t = vb >> 1;
                11: t = vb << 1;
                12: begin t = va; for (int k = 0; k < (b % W); k++) t = {t[6:0], t[7]}; end
                13: begin t = va; for (int k = 0; k < (b % W); k++) t = {t[0], t[7:1]}; end
                default: begin t = 8'h00; bad = 1; end
            endcase
            r = int'(t);
            if (c <= 5 || c == 12 || c == 13) begin na = 1; nb = 1; end
            if (c == 6 || c == 8 || c == 9) na = 1;
            if (c == 7 || c == 10 || c == 11) nb = 1;
            if ((c == 12 || c == 13) && b >= W) bad = 1;
        end
        if ((na && !iv[0]) || (nb && !iv[1]) || iv == 2'b00) bad = 1;
        if (bad) return 15'b000000000_000001;
        return {9'(r), co, of, gg, ll, ee, 1'b0};
    endfunction

    function automatic logic [14:0] actual();
        return {bus.res, bus.cout, bus.oflow, bus.g, bus.l, bus.e, bus.err};
    endfunction

    // Reference model tracks reset, clock enable and the one-cycle latency.
    logic [14:0] exp_q = '0;
    bit started = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q   = '0;
                started = 1;
            end else if (bus.ce) begin
                exp_q = model(bus.mode, int'(bus.cmd), int'(bus.opa), int'(bus.opb),
                              int'(bus.cin), bus.inp_valid);
            end
            #1;
            if (started) begin
                nchecks++;
                if (actual() !== exp_q) begin
                    nfail++;
                    $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, actual(), exp_q);
                end
            end
        end
    end

    task automatic step(input logic md, input int c, input int a, input int b,
                        input logic ci, input logic [1:0] iv, input logic en);
        @(negedge clk);
        bus.mode      = md;
        bus.cmd       = 4'(c);
        bus.opa       = 8'(a);
        bus.opb       = 8'(b);
        bus.cin       = ci;
        bus.inp_valid = iv;
        bus.ce        = en;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [8:0] r, input logic [5:0] f);
        nchecks++;
        if (actual() !== {r, f}) begin
            nfail++;
            $display("FAIL %s got res=%h flags=%b expected res=%h flags=%b",
                     name, bus.res, actual() & 15'h3f, r, f);
        end
    endtask

    // Flags order in literals: cout oflow g l e err
    initial begin
        bus.ce = 1'b0; bus.mode = 1'b0; bus.cmd = '0; bus.opa = '0; bus.opb = '0;
        bus.cin = 1'b0; bus.inp_valid = 2'b00;
        rst = 1'b1;
        step(1, 0, 8'hFF, 8'hFF, 0, 2'b11, 1);  chk("reset_edge1", 9'h000, 6'b000000);
        step(1, 0, 8'hFF, 8'hFF, 0, 2'b11, 1);  chk("reset_edge2", 9'h000, 6'b000000);
        rst = 1'b0;
        step(1, 0, 8'hFF, 8'hFF, 0, 2'b11, 1);  chk("add_ff_ff", 9'h1FE, 6'b100000);
        step(1, 3, 8'h05, 8'h05, 1, 2'b11, 1);  chk("sub_cin_borrow", 9'h0FF, 6'b010000);
        step(1, 8, 8'h03, 8'h09, 0, 2'b11, 1);  chk("cmp_less", 9'h000, 6'b000100);
        step(1, 8, 8'h07, 8'h07, 0, 2'b11, 1);  chk("cmp_equal", 9'h000, 6'b000010);
        step(1, 8, 8'hA0, 8'h0A, 0, 2'b11, 1);  chk("cmp_greater", 9'h000, 6'b001000);
        step(0, 12, 8'h81, 8'h01, 0, 2'b11, 1); chk("rol_81_1", 9'h003, 6'b000000);
        step(0, 12, 8'h81, 8'h11, 0, 2'b11, 1); chk("rol_bad_amt", 9'h000, 6'b000001);
        step(0, 13, 8'h81, 8'h01, 0, 2'b11, 1); chk("ror_81_1", 9'h0C0, 6'b000000);
        step(0, 13, 8'h5A, 8'h00, 0, 2'b11, 1); chk("ror_zero_amt", 9'h05A, 6'b000000);
        step(1, 0, 8'h10, 8'h20, 0, 2'b01, 1);  chk("add_missing_b", 9'h000, 6'b000001);
        step(1, 0, 8'h10, 8'h20, 0, 2'b11, 1);  chk("add_err_clears", 9'h030, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            step(i[0], 2 + i, 8'h11 * (i + 1), 8'hC3, 1, 2'b11, 0);
            chk("ce_hold", 9'h030, 6'b000000);
        end
        step(1, 0, 8'h01, 8'h02, 0, 2'b11, 1);  chk("ce_resume", 9'h003, 6'b000000);
        step(0, 14, 8'h12, 8'h34, 0, 2'b11, 1); chk("illegal_log14", 9'h000, 6'b000001);
        step(1, 9, 8'h12, 8'h34, 0, 2'b11, 1);  chk("illegal_arith9", 9'h000, 6'b000001);
        step(1, 5, 8'h00, 8'h00, 0, 2'b01, 1);  chk("dec_a_wrap", 9'h0FF, 6'b010000);
        step(1, 4, 8'hFF, 8'h00, 0, 2'b01, 1);  chk("inc_a_wrap", 9'h100, 6'b100000);
        step(1, 6, 8'h00, 8'h05, 0, 2'b01, 1);  chk("inc_b_missing_b", 9'h000, 6'b000001);
        step(1, 7, 8'h00, 8'h00, 0, 2'b10, 1);  chk("dec_b_wrap", 9'h0FF, 6'b010000);
        step(1, 2, 8'hFF, 8'h00, 1, 2'b11, 1);  chk("add_cin_carry", 9'h100, 6'b100000);
        step(1, 1, 8'h20, 8'h30, 0, 2'b11, 1);  chk("sub_borrow", 9'h0F0, 6'b010000);
        step(0, 11, 8'h00, 8'h81, 0, 2'b10, 1); chk("shl1_b", 9'h002, 6'b000000);
        step(0, 8, 8'h81, 8'h00, 0, 2'b01, 1);  chk("shr1_a", 9'h040, 6'b000000);
        step(0, 1, 8'hF0, 8'h0F, 0, 2'b11, 1);  chk("nand", 9'h0FF, 6'b000000);
        step(0, 5, 8'hF0, 8'h3C, 0, 2'b11, 1);  chk("xnor", 9'h033, 6'b000000);
        step(0, 6, 8'h0F, 8'h00, 0, 2'b00, 1);  chk("valid_00", 9'h000, 6'b000001);
        step(1, 0, 8'h40, 8'h40, 0, 2'b11, 1);  chk("add_plain", 9'h080, 6'b000000);
        rst = 1'b1;
        step(1, 0, 8'h01, 8'h01, 0, 2'b11, 1);  chk("reset_midrun", 9'h000, 6'b000000);
        rst = 1'b0;
        step(0, 2, 8'hA0, 8'h05, 0, 2'b11, 1);  chk("or_after_reset", 9'h0A5, 6'b000000);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule
